// File: rtl/adder32_rr_scheduler_if.sv
// Bundle for the shared-adder scheduler: requester operands/grants, adder operands/result,
// tagged result stream and the issue counter.
interface adder32_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_o;
  logic                  res_valid;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;
  logic                  res_ready;
  logic [31:0]           issue_cnt;

  modport master (
    output req_valid, req_a, req_b, add_o, res_ready,
    input  req_ready, add_a, add_b, res_valid, res_data, res_id, issue_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, add_o, res_ready,
    output req_ready, add_a, add_b, res_valid, res_data, res_id, issue_cnt
  );
endinterface

// File: rtl/adder32_rr_scheduler.sv
// Round-robin sharing of one registered 32-bit adder among NUM_REQ requesters; results come
// back in issue order, tagged with the requester ID, through a credit-protected result FIFO.
module adder32_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int RES_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  adder32_rr_scheduler_if.slave bus
);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int OW = $clog2(RES_DEPTH + 1);
  localparam int CW = $clog2(RES_DEPTH + 3) + 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] grant;
  logic               fire;
  logic               issue_ok;
  logic               head_valid;
  logic               pop;
  logic               push;
  logic [CW-1:0]      credit_use;

  logic [31:0]        add_a_q;
  logic [31:0]        add_b_q;
  logic [31:0]        cnt_q;
  logic               s1_valid;
  logic               s2_valid;
  logic [ID_W-1:0]    s1_tag;
  logic [ID_W-1:0]    s2_tag;

  logic [31:0]        mem_data [RES_DEPTH];
  logic [ID_W-1:0]    mem_id   [RES_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [OW-1:0]      occ;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (32'(p) == 32'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_valid = (occ != '0);
  assign pop        = head_valid & bus.res_ready;
  assign push       = s2_valid;

  // Both in-flight stages reserve a slot, so a landing result always finds room.
  assign credit_use = CW'(occ) + CW'(s1_valid) + CW'(s2_valid) - CW'(pop);
  assign issue_ok   = (credit_use < CW'(RES_DEPTH));

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    fire   = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!fire && bus.req_valid[idx]) begin
        fire        = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
    if (!issue_ok || rst) begin
      grant = '0;
      fire  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q  <= '0;
      add_b_q  <= '0;
      cnt_q    <= '0;
      ptr      <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_tag   <= '0;
      s2_tag   <= '0;
    end else begin
      if (fire) begin
        add_a_q <= bus.req_a[32*gnt_id +: 32];
        add_b_q <= bus.req_b[32*gnt_id +: 32];
        ptr     <= ID_W'((32'(gnt_id) + 32'd1) % NUM_REQ);
        cnt_q   <= cnt_q + 32'd1;
      end
      s1_valid <= fire;
      s1_tag   <= gnt_id;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < RES_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= bus.add_o;
        mem_id[wr_ptr]   <= s2_tag;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  assign bus.req_ready = grant;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.res_valid = head_valid;
  assign bus.res_data  = mem_data[rd_ptr];
  assign bus.res_id    = mem_id[rd_ptr];
  assign bus.issue_cnt = cnt_q;
endmodule

// File: tb/tb_adder32_rr_scheduler.sv
// Bench for adder32_rr_scheduler: directed vectors and sequences plus random traffic,
// scored against a queue-based model of outstanding operations.
module tb_adder32_rr_scheduler;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder32_rr_scheduler_if #(.NUM_REQ(N), .ID_W(IDW)) bus();
  adder32_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW), .RES_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // external registered adder
  always @(posedge clk) bus.add_o <= bus.add_a + bus.add_b;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]    sum;
    logic [IDW-1:0] id;
  } res_t;

  res_t        exp_q[$];
  int          m_ptr;
  int unsigned m_issues;
  bit          mon_cnt_en = 1'b1;
  bit          mon_pop;
  int          mon_out;
  logic [N-1:0] mon_eg;
  res_t        mon_r;

  // Reference: outstanding ops (issued, not yet consumed) form one ordered queue; a grant is
  // allowed while outstanding minus this cycle's pop stays below DEPTH.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_ptr    = 0;
      m_issues = 0;
    end else begin
      mon_pop = bus.res_valid && bus.res_ready;
      mon_out = exp_q.size() - (mon_pop ? 1 : 0);
      mon_eg  = '0;
      if (mon_out < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          if (bus.req_valid[(m_ptr + k) % N]) begin
            mon_eg[(m_ptr + k) % N] = 1'b1;
            break;
          end
        end
      end
      check32("grant", 32'(bus.req_ready), 32'(mon_eg));
      if (mon_cnt_en) check32("issue_cnt", bus.issue_cnt, m_issues);
      if (bus.res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_result: got res_valid=1 expected 0 with nothing outstanding");
        end else begin
          checks--;
          check32("res_data", bus.res_data, exp_q[0].sum);
          check32("res_id", 32'(bus.res_id), 32'(exp_q[0].id));
          if (mon_pop) void'(exp_q.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_r.sum = bus.req_a[32*i +: 32] + bus.req_b[32*i +: 32];
          mon_r.id  = IDW'(i);
          exp_q.push_back(mon_r);
          m_ptr = (i + 1) % N;
          m_issues++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic [31:0] rid, output int lat);
    bit got;
    got = 1'b0;
    d   = '0;
    rid = '0;
    lat = -1;
    bus.req_a[32*id +: 32] = a;
    bus.req_b[32*id +: 32] = b;
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
      else step();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no req_ready[%0d] expected grant within 8 cycles", id);
      bus.req_valid = '0;
      return;
    end
    step();
    bus.req_valid = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        lat = k;
        d   = bus.res_data;
        rid = 32'(bus.res_id);
        break;
      end
    end
    step();
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] d;
  logic [31:0] rid;
  int          lat;
  int          g_log[$];
  res_t        r_log[$];
  int          n_iss;
  int          n_pop;
  int          seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'd5,          32'd7,          32'd12};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'd2,          32'd1};
    vecs[2] = '{2, 32'h8000_0000,  32'h8000_0000,  32'd0};
    vecs[3] = '{3, 32'h1234_5678,  32'h8765_4321,  32'h9999_9999};
    vecs[4] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[5] = '{3, 32'd0,          32'd0,          32'd0};

    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    repeat (2) step();
    check32("rst_req_ready", 32'(bus.req_ready), 0);
    check32("rst_add_a", bus.add_a, 0);
    check32("rst_add_b", bus.add_b, 0);
    check32("rst_res_valid", 32'(bus.res_valid), 0);
    check32("rst_res_data", bus.res_data, 0);
    check32("rst_res_id", 32'(bus.res_id), 0);
    check32("rst_issue_cnt", bus.issue_cnt, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      single_op(vecs[v].id, vecs[v].a, vecs[v].b, d, rid, lat);
      check32("vec_data", d, vecs[v].sum);
      check32("vec_id", rid, 32'(vecs[v].id));
      check32("vec_latency", 32'(lat), 3);
      if (v == 0) check32("single_issue_cnt", bus.issue_cnt, 1);
    end

    // round-robin with every requester continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_a[32*i +: 32] = 32'(i);
      bus.req_b[32*i +: 32] = 32'd100;
    end
    bus.req_valid = '1;
    for (int k = 0; k < 60 && (g_log.size() < 8 || r_log.size() < 4); k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) g_log.push_back(i);
      if (bus.res_valid && bus.res_ready) begin
        mon_r.sum = bus.res_data;
        mon_r.id  = bus.res_id;
        r_log.push_back(mon_r);
      end
    end
    step();
    bus.req_valid = '0;
    if (g_log.size() < 8 || r_log.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL rr_timeout: got %0d grants/%0d results expected 8/4", g_log.size(), r_log.size());
    end else begin
      for (int k = 0; k < 8; k++) check32("rr_grant_order", 32'(g_log[k]), 32'(k % N));
      for (int k = 0; k < 4; k++) begin
        check32("rr_res_data", r_log[k].sum, 32'(100 + k));
        check32("rr_res_id", 32'(r_log[k].id), 32'(k));
      end
    end
    repeat (6) step();
    check32("rr_drained", 32'(exp_q.size()), 0);

    // backpressure: only DEPTH ops may issue while the consumer stalls
    do_reset();
    bus.res_ready = 1'b0;
    bus.req_a[31:0]  = 32'd10;  bus.req_b[31:0]  = 32'd1;
    bus.req_a[63:32] = 32'd20;  bus.req_b[63:32] = 32'd2;
    bus.req_valid = 4'b0011;
    n_iss = 0;
    n_pop = 0;
    repeat (8) begin
      @(negedge clk);
      n_iss += $countones(bus.req_ready & bus.req_valid);
    end
    check32("bp_issued", 32'(n_iss), DEPTH);
    check32("bp_ready_low", 32'(bus.req_ready), 0);
    step();
    bus.res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.req_a[31:0]  = $urandom;
      bus.req_a[63:32] = $urandom;
      @(negedge clk);
      n_iss += $countones(bus.req_ready & bus.req_valid);
      n_pop += (bus.res_valid && bus.res_ready) ? 1 : 0;
      step();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_pop += (bus.res_valid && bus.res_ready) ? 1 : 0;
      step();
    end
    check32("bp_no_loss", 32'(n_pop), 32'(n_iss));
    check32("bp_drained", 32'(exp_q.size()), 0);

    // reset asserted the cycle after an issue
    do_reset();
    bus.req_a[95:64] = 32'd5;
    bus.req_b[95:64] = 32'd9;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check32("mid_pre_grant", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    check32("mid_req_ready", 32'(bus.req_ready), 0);
    check32("mid_add_a", bus.add_a, 0);
    check32("mid_add_b", bus.add_b, 0);
    check32("mid_res_valid", 32'(bus.res_valid), 0);
    check32("mid_issue_cnt", bus.issue_cnt, 0);
    step();
    bus.req_valid = '0;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += bus.res_valid ? 1 : 0;
    end
    check32("mid_no_result", 32'(seen), 0);
    step();
    bus.req_valid = '1;
    @(negedge clk);
    check32("mid_ptr_zero", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    repeat (6) step();

    // issue counter wrap
    mon_cnt_en = 1'b0;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    single_op(1, 32'hFFFF_FFFF, 32'd2, d, rid, lat);
    check32("wrap_data", d, 32'd1);
    check32("wrap_issue_cnt", bus.issue_cnt, 32'd0);
    do_reset();
    mon_cnt_en = 1'b1;

    // random traffic with random consumer stalls
    for (int c = 0; c < 1500; c++) begin
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_a[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        bus.req_b[32*i +: 32] = $urandom;
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (10) step();
    check32("rand_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
